// File: rtl/mul_sequencer.sv
// Radix-2 shift-and-add unsigned multiplier that time-shares one external full adder.
// Latency: START accepted at edge k, DONE pulses in the cycle after edge k+WIDTH; 18-cycle minimum issue interval.
// Backpressure: none; START is only sampled in IDLE, so a request during RUN/FIN is dropped, not queued.

module full_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
endmodule

module mul_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_s,
    input  logic                 add_cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == RUN);
        done    = (state == FIN);
        add_cin = 1'b0;
        add_a   = '0;
        add_b   = '0;
        if (state == RUN) begin
            add_a = acc_hi;
            add_b = acc_lo[0] ? mcand : '0;
        end
    end

    // The adder carry-out becomes the new MSB, so the full 2*WIDTH product never overflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        acc_hi <= '0;
                        acc_lo <= b;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    {acc_hi, acc_lo} <= {add_cout, add_s, acc_lo[WIDTH-1:1]};
                    cnt              <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign p = {acc_hi, acc_lo};

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized scoreboard bench for mul_sequencer wired to a real full_adder_16bit.
module tb_mul_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a_i, b_i;
    logic        busy, done;
    logic [31:0] p;
    logic [15:0] add_a, add_b, add_s;
    logic        add_cin, add_cout;

    always #5 clk = ~clk;

    mul_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i),
        .busy(busy), .done(done), .p(p),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    full_adder_16bit fa (
        .a(add_a), .b(add_b), .cin(add_cin), .s(add_s), .cout(add_cout)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ph counts edges since the accept edge (-1 = idle).
    // ph 0..15 -> iterating, ph 16 -> result cycle, then back to idle.
    int          ph = -1;
    bit          live = 1'b0;
    logic [15:0] op_a, op_b;
    logic [31:0] expq[$];
    logic [31:0] hold;
    bit          hold_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ph = -1;
            expq.delete();
            hold = 32'h0;
            hold_ok = 1'b1;
            live = 1'b1;
        end else if (ph < 0) begin
            if (start) begin
                ph = 0;
                op_a = a_i;
                op_b = b_i;
                expq.push_back({16'h0000, a_i} * {16'h0000, b_i});
                hold_ok = 1'b0;
            end
        end else begin
            ph++;
            if (ph == 17) ph = -1;
        end
    end

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        logic [31:0] e;
        if (live) begin
            check("busy", {31'h0, busy}, {31'h0, (ph >= 0 && ph <= 15)});
            check("done", {31'h0, done}, {31'h0, (ph == 16)});
            check("add_cin", {31'h0, add_cin}, 32'h0);
            if (!(ph >= 0 && ph <= 15)) begin
                check("add_a_idle", {16'h0, add_a}, 32'h0);
                check("add_b_idle", {16'h0, add_b}, 32'h0);
            end else if (op_a == 16'h0 || op_b == 16'h0) begin
                check("add_b_zero_op", {16'h0, add_b}, 32'h0);
            end
            if (done) n_done++;
            if (ph == 16) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got DONE with no expected product at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    check("product", p, e);
                    hold = e;
                    hold_ok = 1'b1;
                end
            end
            if (hold_ok && ph < 0) check("p_hold", p, hold);
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (ph >= 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (ph >= 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", t);
        end
    endtask

    // Issues one request, then scrambles A/B while the multiply runs.
    task automatic do_mul(input logic [15:0] av, input logic [15:0] bv);
        wait_idle();
        a_i   = av;
        b_i   = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_i   = 16'($urandom);
        b_i   = 16'($urandom);
    endtask

    initial begin
        int d0;
        rst   = 1'b1;
        start = 1'b1;
        a_i   = 16'h1111;
        b_i   = 16'h2222;
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        do_mul(16'h0003, 16'h0005);
        do_mul(16'hFFFF, 16'hFFFF);
        do_mul(16'h8000, 16'h8000);
        do_mul(16'h1234, 16'h0000);
        do_mul(16'h0000, 16'h1234);
        wait_idle();

        // START held high: accepts only every 18 cycles
        d0    = n_done;
        a_i   = 16'h000F;
        b_i   = 16'h0011;
        start = 1'b1;
        repeat (54) @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("held_start_done_count", 32'(n_done - d0), 32'd3);

        // Reset mid-run, with START also high during reset
        do_mul(16'h00FF, 16'h00FF);
        repeat (7) @(negedge clk);
        d0    = n_done;
        rst   = 1'b1;
        start = 1'b1;
        a_i   = 16'h0F0F;
        b_i   = 16'h0F0F;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        do_mul(16'h00FF, 16'h00FF);

        for (int i = 0; i < 25; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 5 == 1) ra = 16'hFFFF;
            if (i % 7 == 2) rb = 16'h0001;
            do_mul(ra, rb);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        wait_idle();
        @(negedge clk);
        check("queue_empty", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, operand width; product width is 2*WIDTH; only 16 is required to be supported.
REQ-002 CLK  input  1  rising-edge clock; the only clock.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request pulse; sampled only in IDLE.
REQ-005 A  input  16  multiplicand, unsigned; captured when START is accepted.
REQ-006 B  input  16  multiplier, unsigned; captured when START is accepted.
REQ-007 BUSY  output  1  high while a multiply is iterating.
REQ-008 DONE  output  1  one-cycle pulse; P is valid in this cycle.
REQ-009 P  output  32  unsigned product A*B.
REQ-010 ADD_A  output  16  operand A to the external 16-bit full adder.
REQ-011 ADD_B  output  16  operand B to the external 16-bit full adder.
REQ-012 ADD_CIN  output  1  carry-in to the external full adder; constant 0.
REQ-013 ADD_S  input  16  sum returned by the external adder; combinational, same cycle.
REQ-014 ADD_COUT  input  1  carry-out returned by the external adder.

Function
REQ-015 The block shall implement radix-2 shift-and-add unsigned multiplication, sharing the single external adder; it shall contain no internal adder of its own.
REQ-016 Internal state: MCAND (16b), ACC_HI (16b), ACC_LO (16b), 4-bit iteration counter CNT, FSM.
REQ-017 FSM states: IDLE, RUN, FIN; IDLE->RUN on START; RUN->RUN while CNT<15; RUN->FIN when CNT==15; FIN->IDLE unconditionally.
REQ-018 START accept, at an edge in IDLE with START=1: MCAND<=A, ACC_HI<=0, ACC_LO<=B, CNT<=0.
REQ-019 In RUN, drive ADD_A=ACC_HI and ADD_B=ACC_LO[0] ? MCAND : 16'h0000.
REQ-020 Each RUN edge: {ACC_HI,ACC_LO}<={ADD_COUT,ADD_S,ACC_LO[15:1]}; CNT<=CNT+1.
REQ-021 Outside RUN, ADD_A and ADD_B shall be 0.
REQ-022 Latency: START accepted at edge k; iterations run at edges k+1..k+16; DONE=1 during the cycle after edge k+16 (FIN); DONE=0 after edge k+17.
REQ-023 BUSY=1 exactly while in RUN (16 cycles); BUSY=0 in IDLE and FIN.
REQ-024 P={ACC_HI,ACC_LO}; P shall be a valid product from FIN onward and hold until the next START is accepted.
REQ-025 START while in RUN or FIN shall be ignored, not queued; A and B changes during RUN shall not affect the result.
REQ-026 Products: 16'hFFFF*16'hFFFF must yield 32'hFFFE0001 without overflow; ADD_COUT is the 17th bit of each partial sum.
REQ-027 Back-to-back operation: a START asserted in the IDLE cycle that immediately follows FIN shall be accepted, giving an 18-cycle minimum issue interval.

Reset
REQ-028 On RST=1 at a clock edge: FSM=IDLE, CNT=0, MCAND=0, ACC_HI=0, ACC_LO=0; hence BUSY=0, DONE=0, P=0, ADD_A=0, ADD_B=0, ADD_CIN=0.
REQ-029 RST shall take priority over START and over any in-progress iteration; RST mid-RUN shall abort the operation with no DONE pulse.
REQ-030 START asserted in the same cycle as RST shall be ignored.

Verification
REQ-031 The bench shall instantiate mul_sequencer with the real full_adder_16bit wired to the ADD_* ports, and check P against A*B on every DONE.
REQ-032 Scenario: A=0003, B=0005, START pulse -> BUSY for 16 cycles, DONE on cycle 17 after the accept edge, P=0000000F.
REQ-033 Scenario: A=FFFF, B=FFFF -> P=FFFE0001; A=8000, B=8000 -> P=40000000.
REQ-034 Scenario: A=1234, B=0000, and A=0000, B=1234 -> P=00000000 with normal 16-cycle latency and ADD_B=0 throughout RUN.
REQ-035 Scenario: START held high continuously with A=000F, B=0011 -> one DONE every 18 cycles, each with P=000000FF; START during RUN/FIN is not accepted early.
REQ-036 Scenario: RST asserted at iteration 8 of A=00FF, B=00FF -> next cycle IDLE, P=0, no DONE; a fresh START then gives P=0000FE01.
